// File: rtl/obi_cache_if_pipe.sv
// OBI slave front-end for the key/value cache: queues up to DEPTH requests, issues them
// one at a time to the cache controller and returns responses in order through a skid register.
module obi_cache_if_pipe #(
    parameter int unsigned KEY_WIDTH   = 64,
    parameter int unsigned VALUE_WIDTH = 128,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     obi_req_i,
    input  logic                     obi_we_i,
    input  logic [VALUE_WIDTH/8-1:0] obi_be_i,
    input  logic [KEY_WIDTH-1:0]     obi_addr_i,
    input  logic [VALUE_WIDTH-1:0]   obi_wdata_i,
    output logic                     obi_gnt_o,
    output logic                     obi_rvalid_o,
    output logic [VALUE_WIDTH-1:0]   obi_rdata_o,
    output logic                     obi_err_o,
    input  logic                     obi_rready_i,
    output logic                     ctrl_valid_o,
    input  logic                     ctrl_ready_i,
    output logic [1:0]               ctrl_op_o,
    output logic [KEY_WIDTH-1:0]     ctrl_key_o,
    output logic [VALUE_WIDTH-1:0]   ctrl_value_o,
    input  logic                     ctrl_resp_valid_i,
    output logic                     ctrl_resp_ready_o,
    input  logic                     ctrl_resp_hit_i,
    input  logic [VALUE_WIDTH-1:0]   ctrl_resp_data_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_GET = 2'b00,
        OP_PUT = 2'b01,
        OP_DEL = 2'b10
    } op_e;

    typedef struct packed {
        op_e                    op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } req_entry_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUE,
        C_WAIT
    } c_state_e;

    req_entry_t             fifo_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CW-1:0]          outstanding_q;
    c_state_e               state_q;
    op_e                    inflight_op_q;
    logic                   rvalid_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic                   err_q;

    req_entry_t new_entry;
    req_entry_t head;
    op_e        new_op;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       ctrl_hs;
    logic       obi_hs;

    // Request decode: a write with no byte enables is a DELETE.
    always_comb begin
        new_op = OP_GET;
        if (obi_we_i) begin
            new_op = (|obi_be_i) ? OP_PUT : OP_DEL;
        end
        new_entry.op    = new_op;
        new_entry.key   = obi_addr_i;
        new_entry.value = (new_op == OP_PUT) ? obi_wdata_i : '0;
    end

    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign obi_gnt_o         = obi_req_i & ~rst & (outstanding_q < CW'(DEPTH));
    assign ctrl_valid_o      = (state_q == C_ISSUE) & ~rst;
    assign ctrl_resp_ready_o = (state_q == C_WAIT) & ~rst & (~rvalid_q | obi_rready_i);

    assign ctrl_op_o    = ctrl_valid_o ? head.op    : OP_GET;
    assign ctrl_key_o   = ctrl_valid_o ? head.key   : '0;
    assign ctrl_value_o = ctrl_valid_o ? head.value : '0;

    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

    assign push    = obi_gnt_o;
    assign pop     = ctrl_valid_o & ctrl_ready_i;
    assign ctrl_hs = ctrl_resp_valid_i & ctrl_resp_ready_o;
    assign obi_hs  = rvalid_q & obi_rready_i;

    // Storage only; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            state_q       <= C_IDLE;
            inflight_op_q <= OP_GET;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q      <= rd_ptr_q + PW'(1);
                inflight_op_q <= head.op;
            end

            if (push && !obi_hs) begin
                outstanding_q <= outstanding_q + CW'(1);
            end else if (!push && obi_hs) begin
                outstanding_q <= outstanding_q - CW'(1);
            end

            // A new controller result may overwrite the skid entry in the cycle it drains.
            if (ctrl_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= (inflight_op_q == OP_GET && ctrl_resp_hit_i) ? ctrl_resp_data_i : '0;
                err_q    <= (inflight_op_q != OP_PUT) & ~ctrl_resp_hit_i;
            end else if (obi_hs) begin
                rvalid_q <= 1'b0;
            end

            case (state_q)
                C_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= C_ISSUE;
                    end
                end
                C_ISSUE: begin
                    if (ctrl_ready_i) begin
                        state_q <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    if (ctrl_hs) begin
                        state_q <= fifo_empty ? C_IDLE : C_ISSUE;
                    end
                end
                default: state_q <= C_IDLE;
            endcase
        end
    end

endmodule
